// File: rtl/llsdcard_data.sv
// Card-side DAT0 engine for the SD-over-SPI-pins host.
// Receives write blocks (start bit, data, CRC16, end bit), answers with the
// CRC status token and a busy period, and transmits read blocks with a CRC16.
// Bits are launched on i_pedge and sampled on i_nedge; without a strobe all
// state holds.
module llsdcard_data #(
  parameter logic [15:0] TAPS        = 16'h1021,
  parameter int          BLOCK_BYTES = 512,
  parameter int          BUSY_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_pedge,
  input  logic       i_nedge,
  input  logic       i_rx_enable,
  output logic       o_rx_stb,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_done,
  output logic       o_rx_crc_err,
  input  logic       i_tx_start,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_underrun,
  output logic       o_tx_done,
  output logic       o_busy,
  input  logic       i_sd_data,
  output logic       o_sd_data,
  output logic       o_sd_oe
);

  localparam int BW = $clog2(BLOCK_BYTES + 1);
  // Phase counter must reach 15 (CRC bits) and BUSY_CYCLES+1 (busy tail).
  localparam int CW = $clog2(BUSY_CYCLES + 18);

  localparam logic [BW-1:0] LAST_BYTE = BW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] BUSY_LOW  = CW'(BUSY_CYCLES);
  localparam logic [4:0]    TOK_GOOD  = 5'b00101;
  localparam logic [4:0]    TOK_BAD   = 5'b01011;

  typedef enum logic [3:0] {
    IDLE, RX_DATA, RX_CRC, RX_END, NCRC, TOKEN, BUSY,
    TX_START, TX_DATA, TX_CRC, TX_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     crc_q, crc_d;
  // Shared shifter: rx data byte, received CRC, status token, tx data byte.
  logic [15:0]     sh_q, sh_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            rx_stb_q, rx_stb_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_done_q, rx_done_d;
  logic            rx_crc_err_q, rx_crc_err_d;
  logic            tx_underrun_q, tx_underrun_d;
  logic            tx_done_q, tx_done_d;
  logic            sd_data_q, sd_data_d;
  logic            sd_oe_q, sd_oe_d;
  logic [7:0]      tx_byte_c;
  logic            err_c;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ (((c[15] ^ b) != 1'b0) ? TAPS : 16'h0000);
  endfunction

  // Next-state and next-output computation for the whole data-line engine.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    cnt_d         = cnt_q;
    crc_d         = crc_q;
    sh_d          = sh_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_stb_d      = 1'b0;
    rx_byte_d     = rx_byte_q;
    rx_done_d     = 1'b0;
    rx_crc_err_d  = rx_crc_err_q;
    tx_underrun_d = 1'b0;
    tx_done_d     = 1'b0;
    sd_data_d     = sd_data_q;
    sd_oe_d       = sd_oe_q;
    tx_byte_c     = 8'hFF;
    err_c         = 1'b0;

    // Holding register accepts a byte whenever it is empty.
    if (i_tx_valid && !hold_full_q) begin
      hold_d      = i_tx_byte;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_nedge && i_rx_enable && !i_sd_data) begin
          state_d    = RX_DATA;
          crc_d      = 16'h0000;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
        end else if (i_tx_start) begin
          state_d = TX_START;
        end
      end
      RX_DATA: begin
        if (i_nedge) begin
          crc_d     = crc_step(crc_q, i_sd_data);
          sh_d      = {sh_q[14:0], i_sd_data};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_stb_d   = 1'b1;
            rx_byte_d  = {sh_q[6:0], i_sd_data};
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
              state_d = RX_CRC;
              cnt_d   = '0;
            end
          end
        end
      end
      RX_CRC: begin
        if (i_nedge) begin
          sh_d  = {sh_q[14:0], i_sd_data};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(15)) state_d = RX_END;
        end
      end
      RX_END: begin
        if (i_nedge) begin
          err_c        = (crc_q != sh_q) || !i_sd_data;
          rx_done_d    = 1'b1;
          rx_crc_err_d = err_c;
          sh_d         = {(err_c ? TOK_BAD : TOK_GOOD), 11'd0};
          state_d      = NCRC;
          cnt_d        = '0;
        end
      end
      NCRC: begin
        if (i_pedge) begin
          sd_oe_d   = 1'b1;
          sd_data_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = TOKEN;
            cnt_d   = '0;
          end
        end
      end
      TOKEN: begin
        if (i_pedge) begin
          sd_data_d = sh_q[15];
          sh_d      = {sh_q[14:0], 1'b0};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(4)) begin
            state_d = BUSY;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        if (i_pedge) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q < BUSY_LOW) begin
            sd_data_d = 1'b0;
          end else if (cnt_q == BUSY_LOW) begin
            sd_data_d = 1'b1;
          end else begin
            sd_oe_d   = 1'b0;
            sd_data_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      TX_START: begin
        if (i_pedge) begin
          sd_oe_d    = 1'b1;
          sd_data_d  = 1'b0;
          state_d    = TX_DATA;
          crc_d      = 16'h0000;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
        end
      end
      TX_DATA: begin
        if (i_pedge) begin
          if (bit_cnt_q == 3'd0) begin
            // Reload on bit 7; an empty holding register sends 8'hFF.
            if (hold_full_q) begin
              tx_byte_c   = hold_q;
              hold_full_d = 1'b0;
            end else begin
              tx_byte_c     = 8'hFF;
              tx_underrun_d = 1'b1;
            end
          end else begin
            tx_byte_c = sh_q[7:0];
          end
          sd_data_d = tx_byte_c[7];
          crc_d     = crc_step(crc_q, tx_byte_c[7]);
          sh_d      = {8'h00, tx_byte_c[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
              state_d = TX_CRC;
              cnt_d   = '0;
            end
          end
        end
      end
      TX_CRC: begin
        if (i_pedge) begin
          sd_data_d = crc_q[15];
          crc_d     = {crc_q[14:0], 1'b0};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(15)) begin
            state_d = TX_STOP;
            cnt_d   = '0;
          end
        end
      end
      TX_STOP: begin
        if (i_pedge) begin
          if (cnt_q == '0) begin
            sd_data_d = 1'b1;
            cnt_d     = CW'(1);
          end else begin
            sd_oe_d   = 1'b0;
            sd_data_d = 1'b1;
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any block and releases DAT0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= '0;
      cnt_q         <= '0;
      crc_q         <= 16'h0000;
      sh_q          <= 16'h0000;
      hold_q        <= 8'h00;
      hold_full_q   <= 1'b0;
      rx_stb_q      <= 1'b0;
      rx_byte_q     <= 8'h00;
      rx_done_q     <= 1'b0;
      rx_crc_err_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      tx_done_q     <= 1'b0;
      sd_data_q     <= 1'b1;
      sd_oe_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      cnt_q         <= cnt_d;
      crc_q         <= crc_d;
      sh_q          <= sh_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_stb_q      <= rx_stb_d;
      rx_byte_q     <= rx_byte_d;
      rx_done_q     <= rx_done_d;
      rx_crc_err_q  <= rx_crc_err_d;
      tx_underrun_q <= tx_underrun_d;
      tx_done_q     <= tx_done_d;
      sd_data_q     <= sd_data_d;
      sd_oe_q       <= sd_oe_d;
    end
  end

  assign o_rx_stb      = rx_stb_q;
  assign o_rx_byte     = rx_byte_q;
  assign o_rx_done     = rx_done_q;
  assign o_rx_crc_err  = rx_crc_err_q;
  assign o_tx_ready    = !hold_full_q;
  assign o_tx_underrun = tx_underrun_q;
  assign o_tx_done     = tx_done_q;
  assign o_busy        = (state_q != IDLE);
  assign o_sd_data     = sd_data_q;
  assign o_sd_oe       = sd_oe_q;

endmodule

// File: tb/tb_llsdcard_data.sv
// Bench for llsdcard_data: a host model drives write blocks and collects
// read blocks; expectations come from a byte-level reference model.
module tb_llsdcard_data;
  localparam int NB = 512;

  typedef logic [7:0] bytes_t[$];
  typedef bit         bits_t[$];

  logic       clk = 1'b0;
  logic       i_reset_n, i_pedge, i_nedge, i_rx_enable;
  logic       o_rx_stb, o_rx_done, o_rx_crc_err;
  logic [7:0] o_rx_byte;
  logic       i_tx_start, i_tx_valid;
  logic [7:0] i_tx_byte;
  logic       o_tx_ready, o_tx_underrun, o_tx_done, o_busy;
  logic       i_sd_data, o_sd_data, o_sd_oe;

  always #5 clk = ~clk;

  llsdcard_data dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_pedge(i_pedge), .i_nedge(i_nedge),
    .i_rx_enable(i_rx_enable), .o_rx_stb(o_rx_stb), .o_rx_byte(o_rx_byte),
    .o_rx_done(o_rx_done), .o_rx_crc_err(o_rx_crc_err),
    .i_tx_start(i_tx_start), .i_tx_valid(i_tx_valid), .i_tx_byte(i_tx_byte),
    .o_tx_ready(o_tx_ready), .o_tx_underrun(o_tx_underrun), .o_tx_done(o_tx_done),
    .o_busy(o_busy), .i_sd_data(i_sd_data), .o_sd_data(o_sd_data), .o_sd_oe(o_sd_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC16: MSB-first over data bits, register starts at 0.
  function automatic logic [15:0] crc_of(input bytes_t d);
    logic [15:0] c = 16'h0000;
    foreach (d[i]) for (int b = 7; b >= 0; b--) begin
      logic fb = c[15] ^ d[i][b];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [31:0] pack_q(input bits_t q);
    logic [31:0] v = 32'h0;
    foreach (q[i]) if (i < 32) v = {v[30:0], 1'(q[i])};
    return v;
  endfunction

  // Monitor state (observations at the falling system-clock edge).
  logic [7:0] rx_q[$];
  bits_t      line_q;
  int         done_n, txdone_n, und_n;
  logic       err_last;

  initial forever begin
    @(negedge clk);
    if (o_rx_stb) rx_q.push_back(o_rx_byte);
    if (o_rx_done) begin done_n++; err_last = o_rx_crc_err; end
    if (o_tx_done) txdone_n++;
    if (o_tx_underrun) und_n++;
    if (i_nedge && o_sd_oe) line_q.push_back(o_sd_data);
  end

  // Host-side stimulus state.
  int         phase = 0;
  bits_t      hostq;
  logic [7:0] feed_q[$];
  int         gap = 0, gap_max = 0, fed = 0;
  bit         last_ready = 1'b0;
  bit         first_bit = 0, arb_req = 0, arm = 0, poke = 0, start_req = 0;
  logic [15:0] last_crc;

  task automatic step();
    @(posedge clk); #1;
    if (i_tx_valid && last_ready) begin
      void'(feed_q.pop_front());
      fed++;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max)) : 0;
    end
    if (phase == 0) phase = 1;
    else if (phase == 1) phase = ($urandom_range(7) == 0) ? 2 : 0;
    else phase = 0;
    i_pedge = (phase == 0);
    i_nedge = (phase == 1);
    if (i_pedge) begin
      if (hostq.size() > 0) begin
        i_sd_data = hostq.pop_front();
        if (first_bit) begin first_bit = 0; arm = arb_req; end
      end else i_sd_data = 1'b1;
    end
    i_tx_start = 1'b0;
    if (start_req) begin i_tx_start = 1'b1; start_req = 0; end
    else if (arm && i_nedge) begin i_tx_start = 1'b1; arm = 0; end
    else if (poke && hostq.size() == 0 && o_busy) i_tx_start = ($urandom_range(1) == 1);
    if (feed_q.size() > 0 && gap == 0) begin
      i_tx_valid = 1'b1;
      i_tx_byte  = feed_q[0];
    end else begin
      i_tx_valid = 1'b0;
      if (gap > 0) gap--;
    end
    last_ready = o_tx_ready;
  endtask

  task automatic clear();
    rx_q.delete(); line_q.delete(); hostq.delete(); feed_q.delete();
    done_n = 0; txdone_n = 0; und_n = 0;
    arm = 0; gap = 0; gap_max = 0; fed = 0;
  endtask

  task automatic do_write(input string name, input bytes_t data, input logic [15:0] crc,
                          input bit endb, input bit arb, input bit exp_err);
    bit ok = 0;
    int mism = 0;
    logic [31:0] exp_line;
    clear();
    i_rx_enable = 1'b1; poke = 1; arb_req = arb; first_bit = 1;
    hostq.push_back(1'b0);
    foreach (data[i]) for (int b = 7; b >= 0; b--) hostq.push_back(data[i][b]);
    for (int b = 15; b >= 0; b--) hostq.push_back(crc[b]);
    hostq.push_back(endb);
    for (int c = 0; c < 12000; c++) begin
      step();
      if (done_n > 0 && !o_busy) begin ok = 1; break; end
    end
    poke = 0; i_rx_enable = 1'b0;
    check_val({name, "_timeout"}, 32'(ok), 32'd1);
    check_val({name, "_rx_cnt"}, rx_q.size(), data.size());
    for (int i = 0; i < rx_q.size() && i < data.size(); i++) if (rx_q[i] !== data[i]) mism++;
    check_val({name, "_rx_data_mism"}, mism, 0);
    check_val({name, "_done_n"}, done_n, 1);
    check_val({name, "_crc_err"}, 32'(err_last), 32'(exp_err));
    exp_line = {16'h0, 2'b11, (exp_err ? 5'b01011 : 5'b00101), 8'h00, 1'b1};
    check_val({name, "_line_n"}, line_q.size(), 16);
    check_val({name, "_line"}, pack_q(line_q), exp_line);
    check_val({name, "_tx_done"}, txdone_n, 0);
    check_val({name, "_oe_rel"}, 32'(o_sd_oe), 32'd0);
    $display("write %s: %0d bytes, crc_err=%0d, token line %04h", name, rx_q.size(), err_last, pack_q(line_q));
  endtask

  task automatic do_read(input string name, input bytes_t data, input int gmax,
                         input int abort_at, input int exp_und);
    bit ok = 0;
    int mism = 0;
    bytes_t sent;
    bits_t exp_bits;
    logic [15:0] mcrc, fcrc;
    clear();
    sent = data;
    while (sent.size() < NB) sent.push_back(8'hFF);
    mcrc = crc_of(sent);
    gap_max = gmax; feed_q = data; start_req = 1;
    for (int c = 0; c < 12000; c++) begin
      step();
      if (abort_at > 0 && fed >= abort_at) begin
        check_val({name, "_pre_oe"}, 32'(o_sd_oe), 32'd1);
        check_val({name, "_pre_busy"}, 32'(o_busy), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check_val({name, "_rst_oe"}, 32'(o_sd_oe), 32'd0);
        check_val({name, "_rst_busy"}, 32'(o_busy), 32'd0);
        check_val({name, "_rst_ready"}, 32'(o_tx_ready), 32'd1);
        feed_q.delete(); i_tx_valid = 1'b0;
        step();
        check_val({name, "_rst_oe2"}, 32'(o_sd_oe), 32'd0);
        check_val({name, "_rst_busy2"}, 32'(o_busy), 32'd0);
        step(); step();
        i_reset_n = 1'b1;
        check_val({name, "_rst_txdone"}, txdone_n, 0);
        $display("read %s: aborted by reset after %0d bytes", name, fed);
        return;
      end
      if (txdone_n > 0 && !o_busy) begin ok = 1; break; end
    end
    check_val({name, "_timeout"}, 32'(ok), 32'd1);
    exp_bits.push_back(1'b0);
    foreach (sent[i]) for (int b = 7; b >= 0; b--) exp_bits.push_back(sent[i][b]);
    for (int b = 15; b >= 0; b--) exp_bits.push_back(mcrc[b]);
    exp_bits.push_back(1'b1);
    check_val({name, "_line_n"}, line_q.size(), exp_bits.size());
    for (int i = 0; i < line_q.size() && i < exp_bits.size(); i++)
      if (line_q[i] != exp_bits[i]) mism++;
    check_val({name, "_line_mism"}, mism, 0);
    fcrc = 16'h0;
    if (line_q.size() >= 8 * NB + 17)
      for (int k = 0; k < 16; k++) fcrc = {fcrc[14:0], 1'(line_q[1 + 8 * NB + k])};
    last_crc = fcrc;
    check_val({name, "_crc"}, fcrc, mcrc);
    check_val({name, "_tx_done"}, txdone_n, 1);
    check_val({name, "_underrun"}, und_n, exp_und);
    check_val({name, "_rx_done"}, done_n, 0);
    check_val({name, "_oe_rel"}, 32'(o_sd_oe), 32'd0);
    $display("read %s: %0d line bits, crc %04h, underruns %0d", name, line_q.size(), fcrc, und_n);
  endtask

  initial begin
    bytes_t ff, rnd, zeros;
    i_reset_n = 1'b0; i_pedge = 0; i_nedge = 0; i_rx_enable = 0;
    i_tx_start = 0; i_tx_valid = 0; i_tx_byte = 8'h00; i_sd_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sd_data", 32'(o_sd_data), 32'd1);
    check_val("rst_oe", 32'(o_sd_oe), 32'd0);
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_ready", 32'(o_tx_ready), 32'd1);
    check_val("rst_rx_byte", 32'(o_rx_byte), 32'd0);
    check_val("rst_pulses", {28'h0, o_rx_stb, o_rx_done, o_tx_done, o_tx_underrun}, 32'd0);
    $display("reset: sd_data=%0d oe=%0d busy=%0d ready=%0d", o_sd_data, o_sd_oe, o_busy, o_tx_ready);
    i_reset_n = 1'b1;
    repeat (4) step();

    for (int i = 0; i < NB; i++) ff.push_back(8'hFF);
    for (int i = 0; i < NB; i++) rnd.push_back(8'($urandom_range(255)));
    for (int i = 0; i < NB - 1; i++) zeros.push_back(8'h00);

    do_write("wr_good", ff, 16'h7FA1, 1'b1, 1'b0, 1'b0);
    do_write("wr_badcrc_arb", ff, 16'h7FA0, 1'b1, 1'b1, 1'b1);
    do_write("wr_rand_arb", rnd, crc_of(rnd), 1'b1, 1'b1, 1'b0);
    do_write("wr_end0", ff, 16'h7FA1, 1'b0, 1'b0, 1'b1);
    do_read("rd_ff", ff, 0, 0, 0);
    check_val("rd_ff_crc_const", last_crc, 16'h7FA1);
    do_read("rd_underrun", zeros, 0, 0, 1);
    rnd.delete();
    for (int i = 0; i < NB; i++) rnd.push_back(8'($urandom_range(255)));
    do_read("rd_rand_gaps", rnd, 4, 0, 0);
    do_read("rd_abort", rnd, 2, 100, 0);
    repeat (4) step();
    rnd.delete();
    for (int i = 0; i < NB; i++) rnd.push_back(8'($urandom_range(255)));
    do_read("rd_after_rst", rnd, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
